// File: rtl/odu_ctr_pkg.sv
// Shared definitions for the ODU channel-control block: FSM states, CTRL/STATUS
// bit positions, register map bases and register-file geometry helpers.
package odu_ctr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } ctr_state_t;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_STOP    = 1;
    localparam int unsigned CTRL_CLR_ERR = 2;

    localparam int unsigned STAT_STATE_LSB = 0;
    localparam int unsigned STAT_ERR_BIT   = 2;
    localparam int unsigned STAT_CNT_LSB   = 8;

    localparam int unsigned ADDR_CTRL    = 0;
    localparam int unsigned ADDR_STATUS  = 1;
    localparam int unsigned ADDR_EN_BASE = 2;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    function automatic int unsigned en_words(input int unsigned num_ch, input int unsigned dw);
        return ceil_div(num_ch, dw);
    endfunction

    function automatic int unsigned type_words(input int unsigned num_ch, input int unsigned type_bits,
                                               input int unsigned dw);
        return ceil_div(num_ch * type_bits, dw);
    endfunction

endpackage

// File: rtl/odu_ctr_data_mc_if.sv
// CPU configuration bus (active-low strobes, registered read data).
interface odu_ctr_data_mc_if #(
    parameter int unsigned DATA_WIDTH_CFG = 16,
    parameter int unsigned ADDR_WIDTH_CFG = 5
) ();

    logic                      cfg_n_cs;
    logic                      cfg_n_we;
    logic                      cfg_n_oe;
    logic [ADDR_WIDTH_CFG-1:0] cfg_addr;
    logic [DATA_WIDTH_CFG-1:0] cfg_din;
    logic [DATA_WIDTH_CFG-1:0] cfg_dout;

    modport master (
        output cfg_n_cs, cfg_n_we, cfg_n_oe, cfg_addr, cfg_din,
        input  cfg_dout
    );

    modport slave (
        input  cfg_n_cs, cfg_n_we, cfg_n_oe, cfg_addr, cfg_din,
        output cfg_dout
    );

endinterface

// File: rtl/odu_cfg_regfile_mc.sv
// Shadow register file: bus write decode, CTRL command strobes and the
// registered read mux. Bits beyond the channel count are never stored.
module odu_cfg_regfile_mc
    import odu_ctr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_CFG = 16,
    parameter int unsigned ADDR_WIDTH_CFG = 5,
    parameter int unsigned NUM_CH         = 80,
    parameter int unsigned TYPE_BITS      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    odu_ctr_data_mc_if.slave              cfg,
    input  logic [DATA_WIDTH_CFG-1:0]     status_word,
    output logic                          ctrl_start,
    output logic                          ctrl_stop,
    output logic                          ctrl_clr,
    output logic [NUM_CH-1:0]             shadow_en,
    output logic [NUM_CH*TYPE_BITS-1:0]   shadow_type
);

    localparam int unsigned DW      = DATA_WIDTH_CFG;
    localparam int unsigned EN_BITS = NUM_CH;
    localparam int unsigned TY_BITS = NUM_CH * TYPE_BITS;
    localparam int unsigned EW      = en_words(NUM_CH, DW);
    localparam int unsigned TW      = type_words(NUM_CH, TYPE_BITS, DW);
    localparam int unsigned TY_BASE = ADDR_EN_BASE + EW;

    logic [EW*DW-1:0] en_q;
    logic [TW*DW-1:0] ty_q;
    logic             wr_en;
    logic             rd_en;
    int unsigned      addr;
    logic [DW-1:0]    rdata;

    function automatic logic [DW-1:0] word_mask(input int unsigned word, input int unsigned total);
        logic [DW-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < DW; b++) begin
            m[b] = (word * DW + b) < total;
        end
        return m;
    endfunction

    always_comb begin
        wr_en      = !cfg.cfg_n_cs && !cfg.cfg_n_we;
        rd_en      = !cfg.cfg_n_cs && cfg.cfg_n_we && !cfg.cfg_n_oe;
        addr       = 32'(cfg.cfg_addr);
        ctrl_start = 1'b0;
        ctrl_stop  = 1'b0;
        ctrl_clr   = 1'b0;
        if (wr_en && addr == ADDR_CTRL) begin
            ctrl_start = cfg.cfg_din[CTRL_START];
            ctrl_stop  = cfg.cfg_din[CTRL_STOP];
            ctrl_clr   = cfg.cfg_din[CTRL_CLR_ERR];
        end
    end

    // Top-word bits past the channel count are masked on write, so the
    // padded storage always reads back zero there.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= '0;
            ty_q <= '0;
        end else if (wr_en) begin
            for (int unsigned w = 0; w < EW; w++) begin
                if (addr == ADDR_EN_BASE + w)
                    en_q[w*DW +: DW] <= cfg.cfg_din & word_mask(w, EN_BITS);
            end
            for (int unsigned w = 0; w < TW; w++) begin
                if (addr == TY_BASE + w)
                    ty_q[w*DW +: DW] <= cfg.cfg_din & word_mask(w, TY_BITS);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (addr == ADDR_STATUS)
            rdata = status_word;
        for (int unsigned w = 0; w < EW; w++) begin
            if (addr == ADDR_EN_BASE + w)
                rdata = en_q[w*DW +: DW];
        end
        for (int unsigned w = 0; w < TW; w++) begin
            if (addr == TY_BASE + w)
                rdata = ty_q[w*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cfg.cfg_dout <= '0;
        else
            cfg.cfg_dout <= rd_en ? rdata : '0;
    end

    assign shadow_en   = en_q[EN_BITS-1:0];
    assign shadow_type = ty_q[TY_BITS-1:0];

endmodule

// File: rtl/odu_ctr_data_mc.sv
// ODU data-generator channel control: run FSM, shadow-to-active commit,
// sticky command error flag and start counter.
module odu_ctr_data_mc
    import odu_ctr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_CFG = 16,
    parameter int unsigned ADDR_WIDTH_CFG = 5,
    parameter int unsigned NUM_CH         = 80,
    parameter int unsigned TYPE_BITS      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    odu_ctr_data_mc_if.slave              cfg,
    input  logic                          gen_idle,
    output logic [NUM_CH-1:0]             enable_chid,
    output logic [NUM_CH*TYPE_BITS-1:0]   type_chid,
    output logic                          run,
    output logic                          start_pulse
);

    ctr_state_t                         state_q;
    ctr_state_t                         state_d;
    logic                               err_q;
    logic                               err_set;
    logic [7:0]                         start_cnt_q;
    logic                               ctrl_start;
    logic                               ctrl_stop;
    logic                               ctrl_clr;
    logic                               start_cmd;
    logic                               stop_cmd;
    logic [DATA_WIDTH_CFG-1:0]          status_word;
    logic [NUM_CH-1:0]                  shadow_en;
    logic [NUM_CH*TYPE_BITS-1:0]        shadow_type;

    odu_cfg_regfile_mc #(
        .DATA_WIDTH_CFG (DATA_WIDTH_CFG),
        .ADDR_WIDTH_CFG (ADDR_WIDTH_CFG),
        .NUM_CH         (NUM_CH),
        .TYPE_BITS      (TYPE_BITS)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg),
        .status_word (status_word),
        .ctrl_start  (ctrl_start),
        .ctrl_stop   (ctrl_stop),
        .ctrl_clr    (ctrl_clr),
        .shadow_en   (shadow_en),
        .shadow_type (shadow_type)
    );

    // STOP dominates a combined START|STOP write.
    assign start_cmd = ctrl_start && !ctrl_stop;
    assign stop_cmd  = ctrl_stop;

    always_comb begin
        status_word                       = '0;
        status_word[STAT_STATE_LSB +: 2]  = state_q;
        status_word[STAT_ERR_BIT]         = err_q;
        status_word[STAT_CNT_LSB +: 8]    = start_cnt_q;
    end

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_cmd)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                err_set = start_cmd;
            end
            ST_RUN: begin
                if (stop_cmd)
                    state_d = ST_DRAIN;
                else
                    err_set = start_cmd;
            end
            ST_DRAIN: begin
                err_set = start_cmd;
                if (gen_idle)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
            start_cnt_q <= '0;
            enable_chid <= '0;
            type_chid   <= '0;
            start_pulse <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set)
                err_q <= 1'b1;
            else if (ctrl_clr)
                err_q <= 1'b0;
            if (state_q == ST_IDLE && state_d == ST_LOAD)
                start_cnt_q <= start_cnt_q + 8'd1;
            // Commit during LOAD so the new config is live on the first RUN cycle.
            if (state_q == ST_LOAD) begin
                enable_chid <= shadow_en;
                type_chid   <= shadow_type;
            end
            start_pulse <= (state_q == ST_LOAD);
        end
    end

    assign run = (state_q == ST_RUN);

endmodule
